ad9228_multich_frame_align: RTL and testbench
=============================================

Name: ad9228_multich_frame_align

Overview:
- Multi-channel successor to the single-lane AD9228 8-to-N gearbox.
- Takes the parallel 8-bit ISERDES words for NUM_CH data lanes plus the FCO lane, all in the dco_div4 domain.
- Regroups each lane into DATA_WIDTH-bit samples.
- Finds frame alignment autonomously by bit-slipping until the deserialised FCO matches its expected pattern, then holds and monitors lock.
- Sits between the per-lane ISERDESE3 instances and the ADC sample FIFO.

Parameters:
NUM_CH, 4, number of data lanes (1..8)
SER_WIDTH, 8, ISERDES word width per lane per dco_div4 cycle
DATA_WIDTH, 12, sample width; must be even and satisfy SER_WIDTH <= DATA_WIDTH <= 2*SER_WIDTH
DIN_INV_MASK, 0, NUM_CH-bit mask; a set bit inverts that lane's input word (board P/N swap)
FCO_INVERTED, 0, inverts the FCO input word
LOCK_FRAMES, 8, consecutive matching FCO frames required to declare lock
SETTLE_FRAMES, 2, frames discarded after each slip
MISS_LIMIT, 4, consecutive FCO mismatches while locked that drop lock

Ports:
dco_div4  in  1  sole clock; all logic is synchronous to it
rstn  in  1  asynchronous active-low reset
ser_data  in  NUM_CH*SER_WIDTH  lane words; lane k occupies [k*SER_WIDTH +: SER_WIDTH]; bit SER_WIDTH-1 is the earliest-received bit
ser_fco  in  SER_WIDTH  FCO lane word, same bit order
ser_valid  in  1  input words valid this cycle
realign  in  1  single-cycle request to drop lock and restart the search
des_data  out  NUM_CH*DATA_WIDTH  samples, MSB = first received bit; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
des_data_valid  out  1  one-cycle strobe per aligned frame
locked  out  1  alignment achieved
slip_pos  out  $clog2(DATA_WIDTH)  current bit-slip offset
align_err  out  1  sticky: a full slip sweep finished without lock
lock_lost  out  1  one-cycle pulse when lock drops because of MISS_LIMIT

Behaviour:
- Reset: all outputs 0, fill counter 0, FSM in SEARCH with counters cleared.
- Gearbox, identical for every lane and for FCO, shares one fill counter `cnt`.
  - On ser_valid: the word is appended below the buffered bits, giving n = cnt + SER_WIDTH, minus 1 when a slip is applied that cycle (the oldest bit is discarded).
  - If n >= DATA_WIDTH, a frame is the oldest DATA_WIDTH bits, and cnt <= n - DATA_WIDTH; otherwise cnt <= n.
  - At most one frame per cycle. Frames are registered and appear 1 cycle after the completing word.
  - When ser_valid = 0, the gearbox holds and no frame is produced.
- Inversion (DIN_INV_MASK, FCO_INVERTED) is applied before buffering.
- Expected FCO frame: DATA_WIDTH/2 ones followed by DATA_WIDTH/2 zeros, i.e. 12'hFC0 for DATA_WIDTH=12.
- FSM states:
  - SEARCH: on each FCO frame, a match increments match_cnt; reaching LOCK_FRAMES goes to LOCKED. A mismatch clears match_cnt and goes to SLIP.
  - SLIP: drives an internal slip for one accepted word. slip_pos increments and wraps DATA_WIDTH-1 -> 0; on wrap, align_err is set. Then goes to SETTLE.
  - SETTLE: discards SETTLE_FRAMES frames, then returns to SEARCH.
  - LOCKED: locked = 1, and des_data_valid mirrors each frame strobe. A mismatch increments miss_cnt; a match clears it. Reaching MISS_LIMIT pulses lock_lost, clears locked, and goes to SEARCH with slip_pos retained.
- Slip timing: a slip requested on a cycle with ser_valid = 0 is held until the next valid word.
- realign has priority over every state: go to SEARCH, locked = 0, clear match/miss counters. slip_pos, align_err and cnt are kept. No lock_lost pulse is generated.
- des_data_valid is never asserted outside LOCKED. des_data holds its last value between strobes.
- Async reset mid-operation returns everything to reset values immediately.
- align_err clears only on reset.

Optional Feature:
AD9228_FRAME_ERR_CNT_EN
- Defined: adds output frame_err_cnt [15:0], a saturating count (stops at 16'hFFFF) of FCO mismatches seen while LOCKED. It clears on reset or realign.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Aligned stream (FCO words 8'hFC,8'h0F,8'hC0 repeating; lane0 carrying 12'hA5C,12'h3F1) -> locked after 8 frames with slip_pos=0; des_data lane0 = 12'hA5C then 12'h3F1; 2 valid strobes per 3 input cycles.
- Stream offset by 5 bits -> 5 slips, with SETTLE_FRAMES frames discarded after each; locked with slip_pos=5; lane samples bit-exact to the transmitted values.
- Lane 2 with DIN_INV_MASK=4'b0100 fed inverted data -> lane 2 output equals the original samples.
- While locked, corrupt 3 consecutive FCO frames, then 4 consecutive -> no drop after 3; lock_lost pulses once after the 4th and locked = 0. With the macro, frame_err_cnt = 7.
- Never-matching FCO (all zeros) -> slip_pos sweeps 0..11 and wraps; align_err = 1; locked stays 0.
- Assert realign while locked, with ser_valid gaps during the search -> locked falls the next cycle, no lock_lost pulse, relock completes; async rstn low mid-SETTLE -> all outputs 0.

Source files
------------

// File: rtl/ad9228_multich_frame_align.sv
// ad9228_multich_frame_align: per-lane SER_WIDTH-to-DATA_WIDTH gearbox with autonomous FCO bit-slip frame alignment.
// Optional macro AD9228_FRAME_ERR_CNT_EN adds a saturating frame_err_cnt of FCO mismatches seen while locked.
module ad9228_multich_frame_align #(
  parameter int NUM_CH = 4,
  parameter int SER_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter logic [NUM_CH-1:0] DIN_INV_MASK = '0,
  parameter bit FCO_INVERTED = 1'b0,
  parameter int LOCK_FRAMES = 8,
  parameter int SETTLE_FRAMES = 2,
  parameter int MISS_LIMIT = 4
) (
  input  logic dco_div4,
  input  logic rstn,
  input  logic [NUM_CH*SER_WIDTH-1:0] ser_data,
  input  logic [SER_WIDTH-1:0] ser_fco,
  input  logic ser_valid,
  input  logic realign,
  output logic [NUM_CH*DATA_WIDTH-1:0] des_data,
  output logic des_data_valid,
  output logic locked,
  output logic [$clog2(DATA_WIDTH)-1:0] slip_pos,
  output logic align_err,
  output logic lock_lost
`ifdef AD9228_FRAME_ERR_CNT_EN
  ,
  output logic [15:0] frame_err_cnt
`endif
);
  localparam int CW = $clog2(DATA_WIDTH + SER_WIDTH);
  localparam int PW = $clog2(DATA_WIDTH);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);
  localparam int TW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [DATA_WIDTH-1:0] FCO_PAT = {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};

  typedef enum logic [1:0] {S_SEARCH, S_SLIP, S_SETTLE, S_LOCKED} state_t;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_n;
  logic r_fv, w_slip, w_full, w_hit, w_miss, w_lost;
  logic [DATA_WIDTH-1:0] w_fco;
  logic [MW-1:0] r_match;
  logic [XW-1:0] r_miss;
  logic [TW-1:0] r_settle;
  logic [PW-1:0] r_slip_pos;
  logic r_err;

  // A slip drops the oldest buffered bit, so the frame boundary moves one bit later.
  assign w_slip = (r_state == S_SLIP) && !realign;
  assign w_n = r_cnt + CW'(SER_WIDTH) - CW'(w_slip);
  assign w_full = w_n >= CW'(DATA_WIDTH);

  for (genvar k = 0; k <= NUM_CH; k++) begin : g_lane
    logic [SER_WIDTH-1:0] w_word;
    logic [DATA_WIDTH+SER_WIDTH-1:0] w_cat;
    logic [DATA_WIDTH-1:0] r_buf, r_frame;
    if (k < NUM_CH) begin : g_dat
      assign w_word = ser_data[k*SER_WIDTH +: SER_WIDTH] ^ {SER_WIDTH{DIN_INV_MASK[k]}};
      assign des_data[k*DATA_WIDTH +: DATA_WIDTH] = r_frame;
    end else begin : g_fco
      assign w_word = ser_fco ^ {SER_WIDTH{FCO_INVERTED}};
      assign w_fco = r_frame;
    end
    assign w_cat = {r_buf, w_word};
    always_ff @(posedge dco_div4 or negedge rstn)
      if (!rstn) begin
        r_buf <= '0;
        r_frame <= '0;
      end else if (ser_valid) begin
        r_buf <= w_cat[DATA_WIDTH-1:0];
        if (w_full) r_frame <= DATA_WIDTH'(w_cat >> (w_n - CW'(DATA_WIDTH)));
      end
  end

  always_ff @(posedge dco_div4 or negedge rstn)
    if (!rstn) begin
      r_cnt <= '0;
      r_fv <= 1'b0;
    end else begin
      r_fv <= ser_valid && w_full;
      if (ser_valid) r_cnt <= w_full ? w_n - CW'(DATA_WIDTH) : w_n;
    end

  assign w_hit = r_fv && (w_fco == FCO_PAT);
  assign w_miss = r_fv && (w_fco != FCO_PAT);
  assign w_lost = (r_state == S_LOCKED) && w_miss && (r_miss == XW'(MISS_LIMIT - 1)) && !realign;

  always_ff @(posedge dco_div4 or negedge rstn)
    if (!rstn) r_state <= S_SEARCH;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SEARCH: w_next = w_miss ? S_SLIP : (w_hit && r_match == MW'(LOCK_FRAMES - 1)) ? S_LOCKED : S_SEARCH;
      S_SLIP:   w_next = ser_valid ? S_SETTLE : S_SLIP;
      S_SETTLE: w_next = (r_fv && r_settle == TW'(SETTLE_FRAMES - 1)) ? S_SEARCH : S_SETTLE;
      S_LOCKED: w_next = w_lost ? S_SEARCH : S_LOCKED;
      default:  w_next = S_SEARCH;
    endcase
    if (realign) w_next = S_SEARCH;
  end

  always_comb begin
    locked = r_state == S_LOCKED;
    des_data_valid = (r_state == S_LOCKED) && r_fv;
    lock_lost = w_lost;
  end

  always_ff @(posedge dco_div4 or negedge rstn)
    if (!rstn) begin
      r_match <= '0;
      r_miss <= '0;
      r_settle <= '0;
      r_slip_pos <= '0;
      r_err <= 1'b0;
    end else begin
      r_match <= (realign || r_state != S_SEARCH || w_miss) ? '0 : r_match + MW'(w_hit);
      r_miss <= (realign || r_state != S_LOCKED || w_hit) ? '0 : r_miss + XW'(w_miss);
      r_settle <= (realign || r_state != S_SETTLE) ? '0 : r_settle + TW'(r_fv);
      if (w_slip && ser_valid) begin
        r_slip_pos <= (r_slip_pos == PW'(DATA_WIDTH - 1)) ? '0 : r_slip_pos + 1'b1;
        r_err <= r_err || (r_slip_pos == PW'(DATA_WIDTH - 1));
      end
    end

  assign slip_pos = r_slip_pos;
  assign align_err = r_err;

`ifdef AD9228_FRAME_ERR_CNT_EN
  logic [15:0] r_ferr;
  always_ff @(posedge dco_div4 or negedge rstn)
    if (!rstn) r_ferr <= '0;
    else if (realign) r_ferr <= '0;
    else if (r_state == S_LOCKED && w_miss && r_ferr != 16'hFFFF) r_ferr <= r_ferr + 16'd1;
  assign frame_err_cnt = r_ferr;
`endif
endmodule

// File: tb/tb_ad9228_multich_frame_align.sv
// tb_ad9228_multich_frame_align: table-driven alignment scenarios plus hand sequences, checked each cycle
// against a bit-queue reference model of the gearbox and alignment state machine.
module tb_ad9228_multich_frame_align;
  localparam int NC = 4;
  localparam int SW = 8;
  localparam int DW = 12;
  localparam logic [NC-1:0] MASK = 4'b0100;
  localparam int LOCKF = 8;
  localparam int SETF = 2;
  localparam int MISSL = 4;
  localparam logic [DW-1:0] FCO_OK = 12'hFC0;
  localparam int M_SEARCH = 0, M_SLIP = 1, M_SETTLE = 2, M_LOCKED = 3;

  typedef struct {
    int off;
    bit zf;
    int vpct;
    int ncyc;
    bit lk;
    int sp;
    bit ae;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NC*SW-1:0] ser_data = '0;
  logic [SW-1:0] ser_fco = '0;
  logic ser_valid = 1'b0;
  logic realign = 1'b0;
  logic [NC*DW-1:0] des_data;
  logic des_data_valid, locked, align_err, lock_lost;
  logic [3:0] slip_pos;
`ifdef AD9228_FRAME_ERR_CNT_EN
  logic [15:0] frame_err_cnt;
`endif

  always #5 clk = ~clk;

  ad9228_multich_frame_align #(.NUM_CH(NC), .SER_WIDTH(SW), .DATA_WIDTH(DW), .DIN_INV_MASK(MASK)) dut (
    .dco_div4(clk), .rstn(rstn), .ser_data(ser_data), .ser_fco(ser_fco), .ser_valid(ser_valid),
    .realign(realign), .des_data(des_data), .des_data_valid(des_data_valid), .locked(locked),
    .slip_pos(slip_pos), .align_err(align_err), .lock_lost(lock_lost)
`ifdef AD9228_FRAME_ERR_CNT_EN
    , .frame_err_cnt(frame_err_cnt)
`endif
  );

  int vecs = 0;
  int errs = 0;
  bit tx [NC+1][$];
  bit rq [NC+1][$];
  logic [SW-1:0] cur_w [NC+1];
  int tx_ph, corrupt, lost_seen;
  bit zero_fco;
  int mode, m_match, m_miss, m_settle, m_slip, m_ferr;
  bit m_err, m_fv;
  logic [DW-1:0] m_frame [NC+1];

  function automatic void tx_frame();
    logic [DW-1:0] s [NC+1];
    bit inv;
    for (int k = 0; k < NC; k++) s[k] = DW'($urandom);
    s[0] = tx_ph ? 12'h3F1 : 12'hA5C;
    s[2] = tx_ph ? 12'hC0E : 12'h5A3;
    s[NC] = zero_fco ? 12'h000 : (corrupt > 0) ? 12'hFC1 : FCO_OK;
    if (corrupt > 0) corrupt--;
    tx_ph = 1 - tx_ph;
    for (int k = 0; k <= NC; k++) begin
      inv = (k < NC) ? MASK[k] : 1'b0;
      for (int b = DW - 1; b >= 0; b--) tx[k].push_back(s[k][b] ^ inv);
    end
  endfunction

  function automatic void tx_reset(input int off, input bit zf);
    for (int k = 0; k <= NC; k++) begin
      tx[k].delete();
      for (int b = 0; b < off; b++) tx[k].push_back(1'($urandom));
    end
    tx_ph = 0;
    corrupt = 0;
    zero_fco = zf;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k <= NC; k++) begin
      rq[k].delete();
      m_frame[k] = '0;
    end
    mode = M_SEARCH;
    m_match = 0; m_miss = 0; m_settle = 0; m_slip = 0; m_ferr = 0;
    m_err = 1'b0; m_fv = 1'b0;
  endfunction

  // Receiver as bit queues: append word, drop the oldest bit on a slip, pop DW bits when available.
  function automatic void model_step(input bit v, input bit ra);
    bit ok, ev, nfv, inv;
    logic [DW-1:0] nf [NC+1];
    ok = m_frame[NC] == FCO_OK;
    ev = m_fv;
    nfv = 1'b0;
    for (int k = 0; k <= NC; k++) nf[k] = '0;
    if (v) begin
      for (int k = 0; k <= NC; k++) begin
        inv = (k < NC) ? MASK[k] : 1'b0;
        for (int b = SW - 1; b >= 0; b--) rq[k].push_back(cur_w[k][b] ^ inv);
        if (mode == M_SLIP && !ra) void'(rq[k].pop_front());
      end
      if (rq[0].size() >= DW) begin
        nfv = 1'b1;
        for (int k = 0; k <= NC; k++)
          for (int b = 0; b < DW; b++) nf[k] = {nf[k][DW-2:0], rq[k].pop_front()};
      end
    end
    if (ra) begin
      mode = M_SEARCH; m_match = 0; m_miss = 0; m_settle = 0; m_ferr = 0;
    end else if (mode == M_SEARCH) begin
      if (ev && ok) begin
        m_match++;
        if (m_match == LOCKF) begin mode = M_LOCKED; m_match = 0; end
      end else if (ev) begin
        m_match = 0; mode = M_SLIP;
      end
    end else if (mode == M_SLIP) begin
      if (v) begin
        m_slip = (m_slip + 1) % DW;
        if (m_slip == 0) m_err = 1'b1;
        mode = M_SETTLE; m_settle = 0;
      end
    end else if (mode == M_SETTLE) begin
      if (ev) begin
        m_settle++;
        if (m_settle == SETF) mode = M_SEARCH;
      end
    end else if (ev) begin
      if (ok) m_miss = 0;
      else begin
        m_miss++;
        if (m_ferr < 65535) m_ferr++;
        if (m_miss == MISSL) begin mode = M_SEARCH; m_miss = 0; end
      end
    end
    m_fv = nfv;
    if (nfv) for (int k = 0; k <= NC; k++) m_frame[k] = nf[k];
  endfunction

  task automatic check(input string nm, input bit ra);
    logic [NC*DW-1:0] ed;
    logic [DW-1:0] l0, l2;
    bit el, edv, elost;
    for (int k = 0; k < NC; k++) ed[k*DW +: DW] = m_frame[k];
    el = mode == M_LOCKED;
    edv = el && m_fv;
    elost = el && m_fv && !ra && m_frame[NC] != FCO_OK && m_miss == MISSL - 1;
    vecs++;
    if (des_data !== ed || des_data_valid !== edv || locked !== el || slip_pos !== 4'(m_slip) ||
        align_err !== m_err || lock_lost !== elost) begin
      errs++;
      $display("FAIL %s t=%0t dut data=%h dv=%b lk=%b sp=%0d ae=%b ll=%b model data=%h dv=%b lk=%b sp=%0d ae=%b ll=%b",
               nm, $time, des_data, des_data_valid, locked, slip_pos, align_err, lock_lost,
               ed, edv, el, m_slip, m_err, elost);
    end
`ifdef AD9228_FRAME_ERR_CNT_EN
    vecs++;
    if (frame_err_cnt !== 16'(m_ferr)) begin
      errs++;
      $display("FAIL %s_ferr t=%0t dut=%0d model=%0d", nm, $time, frame_err_cnt, m_ferr);
    end
`endif
    if (des_data_valid === 1'b1) begin
      l0 = des_data[DW-1:0];
      l2 = des_data[3*DW-1:2*DW];
      vecs++;
      if (!((l0 == 12'hA5C && l2 == 12'h5A3) || (l0 == 12'h3F1 && l2 == 12'hC0E))) begin
        errs++;
        $display("FAIL %s_sample t=%0t lane0=%h lane2=%h want A5C/5A3 or 3F1/C0E", nm, $time, l0, l2);
      end
    end
    if (lock_lost === 1'b1) lost_seen++;
  endtask

  task automatic cycle(input bit v, input bit ra);
    if (tx[0].size() < SW) tx_frame();
    for (int k = 0; k <= NC; k++) begin
      cur_w[k] = v ? '0 : SW'($urandom);
      if (v) for (int b = 0; b < SW; b++) cur_w[k] = {cur_w[k][SW-2:0], tx[k].pop_front()};
    end
    for (int k = 0; k < NC; k++) ser_data[k*SW +: SW] = cur_w[k];
    ser_fco = cur_w[NC];
    ser_valid = v;
    realign = ra;
    @(negedge clk);
    check("cycle", ra);
    model_step(v, ra);
    @(posedge clk);
    #1;
    realign = 1'b0;
  endtask

  task automatic run(input int n, input int vpct);
    for (int c = 0; c < n; c++) cycle($urandom_range(99) < vpct, 1'b0);
  endtask

  task automatic do_reset(input int off, input bit zf);
    rstn = 1'b0;
    ser_valid = 1'b0;
    realign = 1'b0;
    model_reset();
    tx_reset(off, zf);
    @(posedge clk);
    #1;
    check("reset", 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic expect_bit(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut=%b want=%b", nm, act, exp);
    end
  endtask

  initial begin
    vec_t tbl [5];
    bit got;
    tbl[0] = '{0, 1'b0, 100, 60, 1'b1, 0, 1'b0};
    tbl[1] = '{5, 1'b0, 100, 200, 1'b1, 5, 1'b0};
    tbl[2] = '{5, 1'b0, 70, 300, 1'b1, 5, 1'b0};
    tbl[3] = '{11, 1'b0, 100, 300, 1'b1, 11, 1'b0};
    tbl[4] = '{0, 1'b1, 100, 400, 1'b0, -1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_reset(tbl[i].off, tbl[i].zf);
      run(tbl[i].ncyc, tbl[i].vpct);
      expect_bit($sformatf("row%0d_locked", i), locked, tbl[i].lk);
      expect_bit($sformatf("row%0d_align_err", i), align_err, tbl[i].ae);
      if (tbl[i].sp >= 0) begin
        vecs++;
        if (slip_pos !== 4'(tbl[i].sp)) begin
          errs++;
          $display("FAIL row%0d_slip_pos dut=%0d want=%0d", i, slip_pos, tbl[i].sp);
        end
      end
    end

    do_reset(0, 1'b0);
    run(40, 100);
    expect_bit("pre_miss_lock", locked, 1'b1);
    corrupt = 3;
    lost_seen = 0;
    run(30, 100);
    expect_bit("miss3_no_drop", locked, 1'b1);
    expect_bit("miss3_no_pulse", lost_seen != 0, 1'b0);
    corrupt = 4;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle(1'b1, 1'b0);
      got = lost_seen != 0;
    end
    expect_bit("miss4_pulse", got, 1'b1);
    expect_bit("miss4_unlocked", locked, 1'b0);
    run(30, 100);
    expect_bit("miss4_single_pulse", lost_seen == 1, 1'b1);
    expect_bit("relock_after_miss", locked, 1'b1);
`ifdef AD9228_FRAME_ERR_CNT_EN
    vecs++;
    if (frame_err_cnt !== 16'd7) begin
      errs++;
      $display("FAIL frame_err_cnt dut=%0d want=7", frame_err_cnt);
    end
`endif

    lost_seen = 0;
    cycle(1'b1, 1'b1);
    expect_bit("realign_drop", locked, 1'b0);
    for (int c = 0; c < 300 && locked !== 1'b1; c++) cycle($urandom_range(99) < 60, 1'b0);
    expect_bit("realign_relock", locked, 1'b1);
    expect_bit("realign_no_lost", lost_seen != 0, 1'b0);
    expect_bit("realign_slip_kept", slip_pos == 4'd0, 1'b1);

    do_reset(5, 1'b0);
    for (int c = 0; c < 100 && mode != M_SETTLE; c++) cycle(1'b1, 1'b0);
    expect_bit("reach_settle", mode == M_SETTLE, 1'b1);
    #1 rstn = 1'b0;
    #1;
    vecs++;
    if (des_data !== '0 || des_data_valid !== 1'b0 || locked !== 1'b0 || slip_pos !== 4'd0 ||
        align_err !== 1'b0 || lock_lost !== 1'b0) begin
      errs++;
      $display("FAIL async_rst data=%h dv=%b lk=%b sp=%0d ae=%b ll=%b want all zero",
               des_data, des_data_valid, locked, slip_pos, align_err, lock_lost);
    end
    model_reset();
    tx_reset(5, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run(200, 100);
    expect_bit("post_rst_lock", locked, 1'b1);
    expect_bit("post_rst_slip5", slip_pos == 4'd5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
